// File: rtl/liteic_slave_node_wr_arbiter_if.sv
// Write-arbiter bundle for one liteic slave node: crossbar requests and slave
// handshakes in, grant steering and per-channel phase enables out.
interface liteic_slave_node_wr_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]  req_i;
  logic                aw_hs_i;
  logic                w_hs_i;
  logic                b_hs_i;
  logic                grant_valid_o;
  logic [NUM_REQ-1:0]  grant_onehot_o;
  logic [ID_WIDTH-1:0] grant_id_o;
  logic                aw_open_o;
  logic                w_open_o;
  logic                b_open_o;

  // Arbiter side
  modport slave (
    input  req_i, aw_hs_i, w_hs_i, b_hs_i,
    output grant_valid_o, grant_onehot_o, grant_id_o, aw_open_o, w_open_o, b_open_o
  );

  // Crossbar / slave-node side
  modport master (
    output req_i, aw_hs_i, w_hs_i, b_hs_i,
    input  grant_valid_o, grant_onehot_o, grant_id_o, aw_open_o, w_open_o, b_open_o
  );
endinterface

// File: rtl/liteic_slave_node_wr_arbiter.sv
// Round-robin write arbiter for a liteic slave node: grants one master slot per
// write transaction and holds it through AW/W and B phases.
module liteic_slave_node_wr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  liteic_slave_node_wr_arbiter_if.slave  bus
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ADDR_DATA,
    RESP
  } state_t;

  state_t              state;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic                aw_done;
  logic                w_done;
  logic [ID_WIDTH-1:0] sel_id;
  logic                aw_done_nx;
  logic                w_done_nx;

  // First requesting slot at or after ptr, wrapping at NUM_REQ-1 -> 0.
  function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [NUM_REQ-1:0]  req,
                                                  input logic [ID_WIDTH-1:0] ptr);
    logic [ID_WIDTH-1:0] pick;
    int                  idx;
    pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[ID_WIDTH'(idx)]) pick = ID_WIDTH'(idx);
    end
    return pick;
  endfunction

  assign sel_id     = rr_pick(bus.req_i, rr_ptr);
  assign aw_done_nx = aw_done | bus.aw_hs_i;
  assign w_done_nx  = w_done  | bus.w_hs_i;

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state              <= IDLE;
      rr_ptr             <= '0;
      aw_done            <= 1'b0;
      w_done             <= 1'b0;
      bus.grant_valid_o  <= 1'b0;
      bus.grant_onehot_o <= '0;
      bus.grant_id_o     <= '0;
      bus.aw_open_o      <= 1'b0;
      bus.w_open_o       <= 1'b0;
      bus.b_open_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_i) begin
            state              <= ADDR_DATA;
            bus.grant_id_o     <= sel_id;
            bus.grant_onehot_o <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_id;
            bus.grant_valid_o  <= 1'b1;
            bus.aw_open_o      <= 1'b1;
            bus.w_open_o       <= 1'b1;
            aw_done            <= 1'b0;
            w_done             <= 1'b0;
          end
        end
        ADDR_DATA: begin
          // Repeated handshakes after a flag is set leave it set: harmless.
          aw_done       <= aw_done_nx;
          w_done        <= w_done_nx;
          bus.aw_open_o <= !aw_done_nx;
          bus.w_open_o  <= !w_done_nx;
          if (aw_done_nx && w_done_nx) begin
            state        <= RESP;
            bus.b_open_o <= 1'b1;
          end
        end
        RESP: begin
          if (bus.b_hs_i) begin
            state              <= IDLE;
            aw_done            <= 1'b0;
            w_done             <= 1'b0;
            rr_ptr             <= (bus.grant_id_o == ID_WIDTH'(NUM_REQ - 1)) ?
                                  '0 : bus.grant_id_o + ID_WIDTH'(1);
            bus.grant_onehot_o <= '0;
            bus.grant_valid_o  <= 1'b0;
            bus.b_open_o       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(bus.grant_onehot_o));
  a_id_match: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.grant_onehot_o[bus.grant_id_o] == bus.grant_valid_o);
  a_phase_excl: assert property (@(posedge clk_i) disable iff (rst_i)
    !((bus.aw_open_o || bus.w_open_o) && bus.b_open_o));
endmodule

// File: tb/tb_liteic_slave_node_wr_arbiter.sv
// Bench for the liteic write arbiter: 4-slot and 3-slot instances share stimulus
// and are compared every cycle against a transaction-level round-robin model.
module tb_liteic_slave_node_wr_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       aw  = 1'b0;
  logic       w   = 1'b0;
  logic       b   = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  liteic_slave_node_wr_arbiter_if #(.NUM_REQ(4)) if4 ();
  liteic_slave_node_wr_arbiter_if #(.NUM_REQ(3)) if3 ();

  assign if4.req_i   = req;
  assign if4.aw_hs_i = aw;
  assign if4.w_hs_i  = w;
  assign if4.b_hs_i  = b;
  assign if3.req_i   = req[2:0];
  assign if3.aw_hs_i = aw;
  assign if3.w_hs_i  = w;
  assign if3.b_hs_i  = b;

  liteic_slave_node_wr_arbiter #(.NUM_REQ(4)) dut4 (.clk_i(clk), .rst_i(rst), .bus(if4.slave));
  liteic_slave_node_wr_arbiter #(.NUM_REQ(3)) dut3 (.clk_i(clk), .rst_i(rst), .bus(if3.slave));

  // Reference model: phase 0 = idle, 1 = address/data, 2 = response.
  int m_n[2] = '{4, 3};
  int m_phase[2];
  int m_slot[2];
  int m_ptr[2];
  bit m_aw[2];
  bit m_w[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0;
      m_slot[d]  = 0;
      m_ptr[d]   = 0;
      m_aw[d]    = 1'b0;
      m_w[d]     = 1'b0;
    end
  endtask

  task automatic model_step(input logic [3:0] r, input bit a, input bit wv, input bit bv);
    logic [3:0] rd;
    bit         found;
    int         idx;
    for (int d = 0; d < 2; d++) begin
      rd    = (d == 1) ? (r & 4'b0111) : r;
      found = 1'b0;
      case (m_phase[d])
        0: if (rd != 4'b0000) begin
          for (int k = 0; k < m_n[d]; k++) begin
            idx = (m_ptr[d] + k) % m_n[d];
            if (!found && ((rd >> idx) & 4'b0001) != 4'b0000) begin
              found     = 1'b1;
              m_slot[d] = idx;
            end
          end
          m_phase[d] = 1;
          m_aw[d]    = 1'b0;
          m_w[d]     = 1'b0;
        end
        1: begin
          m_aw[d] = m_aw[d] | a;
          m_w[d]  = m_w[d]  | wv;
          if (m_aw[d] && m_w[d]) m_phase[d] = 2;
        end
        default: if (bv) begin
          m_phase[d] = 0;
          m_ptr[d]   = (m_slot[d] + 1) % m_n[d];
        end
      endcase
    end
  endtask

  // Packed {valid, onehot[3:0], id[1:0], aw_open, w_open, b_open}
  function automatic logic [31:0] model_out(input int d);
    logic [31:0] o;
    bit          v;
    v       = (m_phase[d] != 0);
    o       = '0;
    o[9]    = v;
    o[8:5]  = v ? (4'b0001 << m_slot[d]) : 4'b0000;
    o[4:3]  = m_slot[d][1:0];
    o[2]    = (m_phase[d] == 1) && !m_aw[d];
    o[1]    = (m_phase[d] == 1) && !m_w[d];
    o[0]    = (m_phase[d] == 2);
    return o;
  endfunction

  function automatic logic [31:0] act4();
    return 32'({if4.grant_valid_o, if4.grant_onehot_o, if4.grant_id_o,
                if4.aw_open_o, if4.w_open_o, if4.b_open_o});
  endfunction

  function automatic logic [31:0] act3();
    return 32'({if3.grant_valid_o, 1'b0, if3.grant_onehot_o, if3.grant_id_o,
                if3.aw_open_o, if3.w_open_o, if3.b_open_o});
  endfunction

  task automatic step(input logic [3:0] r, input bit a, input bit wv, input bit bv,
                      input string tag);
    req = r;
    aw  = a;
    w   = wv;
    b   = bv;
    model_step(r, a, wv, bv);
    @(posedge clk);
    #1;
    check({tag, "/n4"}, act4(), model_out(0));
    check({tag, "/n3"}, act3(), model_out(1));
  endtask

  typedef struct {
    logic [3:0] req;
    bit         aw;
    bit         w;
    bit         b;
    bit         e_valid;
    logic [1:0] e_id;
    bit         e_aw;
    bit         e_w;
    bit         e_b;
  } vec_t;

  vec_t vecs[17];

  initial begin
    // Tests 1, 4, 3 and out-of-phase handshakes on the 4-slot instance.
    vecs = '{
      '{4'b0001, 0, 0, 0,  1, 2'd0, 1, 1, 0},
      '{4'b0001, 1, 1, 0,  1, 2'd0, 0, 0, 1},
      '{4'b0001, 0, 0, 0,  1, 2'd0, 0, 0, 1},
      '{4'b0001, 0, 0, 1,  0, 2'd0, 0, 0, 0},
      '{4'b0010, 0, 0, 0,  1, 2'd1, 1, 1, 0},
      '{4'b1000, 1, 0, 0,  1, 2'd1, 0, 1, 0},
      '{4'b1000, 0, 1, 0,  1, 2'd1, 0, 0, 1},
      '{4'b1000, 0, 0, 1,  0, 2'd1, 0, 0, 0},
      '{4'b1000, 0, 0, 0,  1, 2'd3, 1, 1, 0},
      '{4'b0000, 0, 1, 0,  1, 2'd3, 1, 0, 0},
      '{4'b0000, 0, 0, 0,  1, 2'd3, 1, 0, 0},
      '{4'b0000, 0, 0, 0,  1, 2'd3, 1, 0, 0},
      '{4'b0000, 1, 0, 0,  1, 2'd3, 0, 0, 1},
      '{4'b0000, 1, 1, 0,  1, 2'd3, 0, 0, 1},
      '{4'b0000, 0, 0, 1,  0, 2'd3, 0, 0, 0},
      '{4'b0000, 0, 0, 1,  0, 2'd3, 0, 0, 0},
      '{4'b0000, 1, 1, 0,  0, 2'd3, 0, 0, 0}
    };

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("in_reset/n4", act4(), 32'd0);
    check("in_reset/n3", act3(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(4'b0000, 0, 0, 0, "idle_after_reset");

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].req, vecs[i].aw, vecs[i].w, vecs[i].b, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_table", i),
            32'({if4.grant_valid_o, if4.grant_id_o, if4.aw_open_o, if4.w_open_o, if4.b_open_o}),
            32'({vecs[i].e_valid, vecs[i].e_id, vecs[i].e_aw, vecs[i].e_w, vecs[i].e_b}));
    end

    // All slots requesting: strict rotation with one dead cycle per transaction.
    for (int t = 0; t < 8; t++) begin
      step(4'b1111, 0, 0, 0, "rr_grant");
      check($sformatf("rr_order%0d", t), 32'(if4.grant_id_o), 32'(t % 4));
      step(4'b1111, 1, 1, 0, "rr_awdata");
      step(4'b1111, 0, 0, 1, "rr_resp");
      check($sformatf("rr_dead%0d", t), 32'(if4.grant_valid_o), 32'd0);
    end

    // Move both pointers to 2, then 2'b11 requests must wrap to slot 0.
    step(4'b0010, 0, 0, 0, "pre_wrap_g");
    step(4'b0000, 1, 1, 0, "pre_wrap_d");
    step(4'b0000, 0, 0, 1, "pre_wrap_b");
    step(4'b0011, 0, 0, 0, "wrap_grant");
    check("wrap_n3_id", 32'(if3.grant_id_o), 32'd0);
    step(4'b0000, 0, 0, 1, "stray_b_in_addr");
    check("stray_b_n3_valid", 32'(if3.grant_valid_o), 32'd1);
    step(4'b0000, 1, 1, 0, "wrap_data");
    step(4'b0000, 1, 0, 0, "stray_aw_in_resp");
    check("stray_aw_n3_bopen", 32'(if3.b_open_o), 32'd1);
    step(4'b0000, 0, 0, 1, "wrap_done");

    // Asynchronous reset while holding slot 2 in the response phase.
    step(4'b0100, 0, 0, 0, "pre_rst_grant");
    check("pre_rst_id", 32'(if4.grant_id_o), 32'd2);
    step(4'b0000, 1, 1, 0, "pre_rst_resp");
    #1 rst = 1'b1;
    #1;
    check("async_rst/n4", act4(), 32'd0);
    check("async_rst/n3", act3(), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(4'b0110, 0, 0, 0, "post_rst_grant");
    check("post_rst_id", 32'(if4.grant_id_o), 32'd1);
    step(4'b0000, 1, 1, 0, "post_rst_data");
    step(4'b0000, 0, 0, 1, "post_rst_resp");

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] r;
      r = 4'($urandom);
      if ($urandom_range(0, 3) == 0) r = 4'b0000;
      step(r, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
